// File: rtl/vmem_pkg.sv
// Shared types and helpers for the virtual-to-physical translator.
// Region and fault codes match the encodings driven on rsp_region/rsp_fault.
package vmem_pkg;

   typedef enum logic [1:0] {
      REGION_NONE  = 2'd0,
      REGION_TEXT  = 2'd1,
      REGION_DATA  = 2'd2,
      REGION_STACK = 2'd3
   } region_e;

   typedef enum logic [1:0] {
      FAULT_OK       = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_UNMAPPED = 2'd2,
      FAULT_WPROT    = 2'd3
   } fault_e;

   localparam logic [1:0] SIZE_BYTE  = 2'd0;
   localparam logic [1:0] SIZE_HALF  = 2'd1;
   localparam logic [1:0] SIZE_WORD  = 2'd2;
   localparam logic [1:0] SIZE_WORD3 = 2'd3;

   // Byte accesses never fault; size 3 is handled exactly like a word.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SIZE_BYTE:             return 1'b0;
         SIZE_HALF:             return lo[0];
         SIZE_WORD, SIZE_WORD3: return lo != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/vmem_region_decode.sv
// Combinational hit test and word-index extraction for one mapped region.
// The limit compare uses a widened bus so a region touching the top of the space cannot wrap.
module vmem_region_decode #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    IDX_WIDTH  = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
   parameter int                    WORDS      = 1
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  hit,
   output logic [IDX_WIDTH-1:0]  index
);

   localparam int EW = ((ADDR_WIDTH > IDX_WIDTH + 2) ? ADDR_WIDTH : IDX_WIDTH + 2) + 1;
   localparam logic [EW-1:0] LO = EW'(BASE);
   localparam logic [EW-1:0] HI = EW'(BASE) + (EW'(WORDS) << 2);

   logic [EW-1:0] addr_ext;

   assign addr_ext = EW'(addr);
   assign hit      = (addr_ext >= LO) && (addr_ext < HI);
   assign index    = IDX_WIDTH'((addr - BASE) >> 2);

endmodule

// File: rtl/vmem_xlate_unit.sv
// Registered virtual-to-physical translator with text/data/stack decode and sticky fault capture.
// Define VMEM_WRITE_PROTECT_EN to make stores into the text region fault with code 3.
module vmem_xlate_unit
   import vmem_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    IDX_WIDTH   = 10,
   parameter logic [ADDR_WIDTH-1:0] TEXT_BASE   = 32'h0040_0000,
   parameter int                    TEXT_WORDS  = 1024,
   parameter logic [ADDR_WIDTH-1:0] DATA_BASE   = 32'h1001_0000,
   parameter int                    DATA_WORDS  = 1024,
   parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 32'h7FFF_E000,
   parameter int                    STACK_WORDS = 1024,
   parameter int                    FCNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_write,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ADDR_WIDTH-1:0] rsp_vaddr,
   output logic [IDX_WIDTH-1:0]  rsp_index,
   output logic [1:0]            rsp_byte_off,
   output logic [1:0]            rsp_region,
   output logic [1:0]            rsp_fault,
   output logic                  fault_pending,
   output logic [ADDR_WIDTH-1:0] badvaddr,
   output logic [FCNT_WIDTH-1:0] fault_count,
   input  logic                  fault_clear
);

`ifdef VMEM_WRITE_PROTECT_EN
   localparam bit WPROT_EN = 1'b1;
`else
   localparam bit WPROT_EN = 1'b0;
`endif

   logic                 text_hit, data_hit, stack_hit;
   logic [IDX_WIDTH-1:0] text_idx, data_idx, stack_idx;

   vmem_region_decode #(
      .ADDR_WIDTH(ADDR_WIDTH), .IDX_WIDTH(IDX_WIDTH), .BASE(TEXT_BASE), .WORDS(TEXT_WORDS)
   ) u_text (.addr(req_addr), .hit(text_hit), .index(text_idx));

   vmem_region_decode #(
      .ADDR_WIDTH(ADDR_WIDTH), .IDX_WIDTH(IDX_WIDTH), .BASE(DATA_BASE), .WORDS(DATA_WORDS)
   ) u_data (.addr(req_addr), .hit(data_hit), .index(data_idx));

   vmem_region_decode #(
      .ADDR_WIDTH(ADDR_WIDTH), .IDX_WIDTH(IDX_WIDTH), .BASE(STACK_BASE), .WORDS(STACK_WORDS)
   ) u_stack (.addr(req_addr), .hit(stack_hit), .index(stack_idx));

   logic                 accept;
   region_e              nx_region;
   fault_e               nx_fault;
   logic [IDX_WIDTH-1:0] nx_index;

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;

   // Fault priority: misaligned, then unmapped, then write-protect.
   always_comb begin
      nx_region = REGION_NONE;
      nx_fault  = FAULT_OK;
      nx_index  = '0;
      if (is_misaligned(req_size, req_addr[1:0])) begin
         nx_fault = FAULT_MISALIGN;
      end else if (!(text_hit || data_hit || stack_hit)) begin
         nx_fault = FAULT_UNMAPPED;
      end else if (WPROT_EN && req_write && text_hit) begin
         nx_fault = FAULT_WPROT;
      end else if (text_hit) begin
         nx_region = REGION_TEXT;
         nx_index  = text_idx;
      end else if (data_hit) begin
         nx_region = REGION_DATA;
         nx_index  = data_idx;
      end else begin
         nx_region = REGION_STACK;
         nx_index  = stack_idx;
      end
   end

   logic                  pend_nx;
   logic [ADDR_WIDTH-1:0] bad_nx;
   logic [FCNT_WIDTH-1:0] cnt_nx;

   // A clear in the same cycle as a faulting accept is applied first.
   always_comb begin
      pend_nx = fault_pending && !fault_clear;
      bad_nx  = fault_clear ? '0 : badvaddr;
      cnt_nx  = fault_clear ? '0 : fault_count;
      if (accept && (nx_fault != FAULT_OK)) begin
         if (!pend_nx) bad_nx = req_addr;
         pend_nx = 1'b1;
         if (cnt_nx != '1) cnt_nx = cnt_nx + FCNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid     <= 1'b0;
         rsp_vaddr     <= '0;
         rsp_index     <= '0;
         rsp_byte_off  <= '0;
         rsp_region    <= '0;
         rsp_fault     <= '0;
         fault_pending <= 1'b0;
         badvaddr      <= '0;
         fault_count   <= '0;
      end else begin
         if (accept) begin
            rsp_valid    <= 1'b1;
            rsp_vaddr    <= req_addr;
            rsp_index    <= nx_index;
            rsp_byte_off <= req_addr[1:0];
            rsp_region   <= nx_region;
            rsp_fault    <= nx_fault;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         fault_pending <= pend_nx;
         badvaddr      <= bad_nx;
         fault_count   <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_vmem_xlate_unit.sv
// Directed plus randomized bench for vmem_xlate_unit against an arithmetic reference model.
module tb_vmem_xlate_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_write;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_vaddr;
   logic [9:0]  rsp_index;
   logic [1:0]  rsp_byte_off, rsp_region, rsp_fault;
   logic        fault_pending;
   logic [31:0] badvaddr;
   logic [7:0]  fault_count;
   logic        fault_clear;

   int total = 0;
   int bad   = 0;

`ifdef VMEM_WRITE_PROTECT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   always #5 clk = ~clk;

   vmem_xlate_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_size(req_size), .req_write(req_write),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vaddr(rsp_vaddr),
      .rsp_index(rsp_index), .rsp_byte_off(rsp_byte_off), .rsp_region(rsp_region),
      .rsp_fault(rsp_fault), .fault_pending(fault_pending), .badvaddr(badvaddr),
      .fault_count(fault_count), .fault_clear(fault_clear)
   );

   // Reference model state
   bit          m_valid;
   logic [31:0] m_vaddr;
   logic [9:0]  m_index;
   logic [1:0]  m_off, m_region, m_fault;
   bit          m_pend;
   logic [31:0] m_bad;
   int          m_cnt;

   function automatic longint base_of(input int r);
      case (r)
         1: return 64'h0040_0000;
         2: return 64'h1001_0000;
         default: return 64'h7FFF_E000;
      endcase
   endfunction

   function automatic void ref_xlate(input logic [31:0] a, input logic [1:0] sz, input logic w,
                                     output logic [1:0] rg, output logic [9:0] ix, output logic [1:0] ft);
      longint ua = longint'(a);
      rg = 0; ix = 0; ft = 0;
      if ((sz == 2'd1 && (ua % 2) != 0) || (sz >= 2'd2 && (ua % 4) != 0)) begin
         ft = 2'd1;
      end else begin
         for (int r = 3; r >= 1; r--)
            if (ua >= base_of(r) && ua < base_of(r) + 4 * 1024) begin
               rg = 2'(r);
               ix = 10'((ua - base_of(r)) / 4);
            end
         if (rg == 0) ft = 2'd2;
         else if (WP && w && rg == 2'd1) ft = 2'd3;
      end
      if (ft != 0) begin
         rg = 0;
         ix = 0;
      end
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rsp_valid"}, rsp_valid, m_valid);
      check({tag, ".rsp_vaddr"}, rsp_vaddr, m_vaddr);
      check({tag, ".rsp_index"}, rsp_index, m_index);
      check({tag, ".rsp_byte_off"}, rsp_byte_off, m_off);
      check({tag, ".rsp_region"}, rsp_region, m_region);
      check({tag, ".rsp_fault"}, rsp_fault, m_fault);
      check({tag, ".fault_pending"}, fault_pending, m_pend);
      check({tag, ".badvaddr"}, badvaddr, m_bad);
      check({tag, ".fault_count"}, fault_count, 64'(m_cnt));
   endtask

   task automatic model_reset();
      m_valid = 0; m_vaddr = 0; m_index = 0; m_off = 0; m_region = 0; m_fault = 0;
      m_pend = 0; m_bad = 0; m_cnt = 0;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [1:0] sz,
                        input logic w, input logic rr, input logic clr);
      req_valid = v; req_addr = a; req_size = sz; req_write = w;
      rsp_ready = rr; fault_clear = clr;
   endtask

   // One clock: check req_ready, advance the model across the edge, compare all outputs.
   task automatic step(input string tag);
      logic        acc;
      logic [1:0]  rg, ft;
      logic [9:0]  ix;
      #1;
      check({tag, ".req_ready"}, req_ready, (!m_valid || rsp_ready));
      acc = req_valid && (!m_valid || rsp_ready);
      ref_xlate(req_addr, req_size, req_write, rg, ix, ft);
      @(posedge clk);
      if (fault_clear) begin
         m_pend = 0; m_bad = 0; m_cnt = 0;
      end
      if (acc) begin
         m_valid = 1; m_vaddr = req_addr; m_off = req_addr % 4;
         m_region = rg; m_index = ix; m_fault = ft;
         if (ft != 0) begin
            if (!m_pend) m_bad = req_addr;
            m_pend = 1;
            if (m_cnt < 255) m_cnt++;
         end
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      #1;
      check_all(tag);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] b;
      case ($urandom_range(0, 4))
         0: b = 32'h0040_0000;
         1: b = 32'h1001_0000;
         2: b = 32'h7FFF_E000;
         3: b = 32'h0000_0000;
         default: b = 32'hFFFF_F000;
      endcase
      return b + 32'($urandom_range(0, 4200)) - 32'd8;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 1, 0);
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Load word in text
      drive(1, 32'h0040_0010, 2'd2, 0, 1, 0); step("ld_text");
      check("ld_text.region", rsp_region, 2'd1);
      check("ld_text.index", rsp_index, 10'd4);
      check("ld_text.fault", rsp_fault, 2'd0);

      // Misaligned half, then unmapped word
      drive(1, 32'h1001_0003, 2'd1, 0, 1, 0); step("mis_half");
      check("mis_half.fault", rsp_fault, 2'd1);
      check("mis_half.badvaddr", badvaddr, 32'h1001_0003);
      check("mis_half.pending", fault_pending, 1'b1);
      check("mis_half.count", fault_count, 8'd1);
      drive(1, 32'h0000_0000, 2'd2, 0, 1, 0); step("unmap0");
      check("unmap0.fault", rsp_fault, 2'd2);
      check("unmap0.badvaddr", badvaddr, 32'h1001_0003);
      check("unmap0.count", fault_count, 8'd2);

      // Region boundaries
      drive(1, 32'h0040_1000, 2'd2, 0, 1, 0); step("text_end");
      check("text_end.fault", rsp_fault, 2'd2);
      drive(1, 32'h7FFF_EFFC, 2'd2, 0, 1, 0); step("stack_top");
      check("stack_top.region", rsp_region, 2'd3);
      check("stack_top.index", rsp_index, 10'd1023);
      drive(1, 32'h1001_0FFF, 2'd0, 0, 1, 0); step("data_last_byte");
      check("data_last_byte.index", rsp_index, 10'd1023);
      check("data_last_byte.off", rsp_byte_off, 2'd3);

      // Store to text start
      drive(1, 32'h0040_0000, 2'd2, 1, 1, 0); step("st_text");
      check("st_text.fault", rsp_fault, WP ? 2'd3 : 2'd0);
      check("st_text.region", rsp_region, WP ? 2'd0 : 2'd1);

      drive(0, 0, 0, 0, 1, 1); step("clear");
      check("clear.pending", fault_pending, 1'b0);
      check("clear.count", fault_count, 8'd0);

      // Backpressure: one held response, a waiting request, then release
      drive(1, 32'h1001_0020, 2'd2, 0, 0, 0); step("bp_first");
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h1001_0024, 2'd2, 0, 0, 0); step("bp_hold");
         check("bp_hold.vaddr", rsp_vaddr, 32'h1001_0020);
         check("bp_hold.req_ready", req_ready, 1'b0);
      end
      drive(1, 32'h1001_0024, 2'd2, 0, 1, 0); step("bp_rel0");
      check("bp_rel0.vaddr", rsp_vaddr, 32'h1001_0024);
      drive(1, 32'h1001_0028, 2'd2, 0, 1, 0); step("bp_rel1");
      check("bp_rel1.vaddr", rsp_vaddr, 32'h1001_0028);
      drive(1, 32'h7FFF_E004, 2'd2, 0, 1, 0); step("bp_rel2");
      check("bp_rel2.index", rsp_index, 10'd1);

      // Fault with clear in the same cycle (a fault is pending beforehand)
      drive(1, 32'h0000_0010, 2'd2, 0, 1, 0); step("pre_clr");
      drive(1, 32'h0040_0002, 2'd2, 0, 1, 1); step("clr_fault");
      check("clr_fault.count", fault_count, 8'd1);
      check("clr_fault.badvaddr", badvaddr, 32'h0040_0002);
      check("clr_fault.pending", fault_pending, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, rand_addr(), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         step("rand");
      end

      // Saturation
      drive(0, 0, 0, 0, 1, 1); step("sat_clr");
      for (int i = 0; i < 260; i++) begin
         drive(1, 32'h0000_0100 + 32'(i * 4), 2'd2, 0, 1, 0);
         step("sat");
      end
      check("sat.count", fault_count, 8'hFF);
      check("sat.badvaddr", badvaddr, 32'h0000_0100);

      // Asynchronous reset with a response in flight
      drive(1, 32'h1001_0040, 2'd2, 0, 0, 0); step("pre_rst");
      #2;
      reset = 1'b1;
      #1;
      check("rst.rsp_valid", rsp_valid, 1'b0);
      check("rst.rsp_vaddr", rsp_vaddr, 32'h0);
      check("rst.rsp_index", rsp_index, 10'h0);
      check("rst.count", fault_count, 8'h0);
      check("rst.badvaddr", badvaddr, 32'h0);
      check("rst.pending", fault_pending, 1'b0);
      model_reset();
      check_all("rst");
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1, 32'h1001_0044, 2'd2, 0, 1, 0); step("post_rst");
      check("post_rst.index", rsp_index, 10'd17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
